noc_packet_sender: RTL and testbench

- Transmit-side packetizer for a NoC router local port; the counterpart of the receive channel (valid/ready/flit/is_header/is_tail).
- Accepts a packet command (destination, payload length) and a payload word stream from the local IP.
- Emits one header flit, then the payload flits, into the router, marking header and tail flits.
- Instantiated once per node, between the local IP and the router injection port.

---
 rtl/noc_packet_sender_pkg.sv | 21 ++
 rtl/noc_packet_sender_if.sv | 43 ++++
 rtl/noc_flit_out_reg.sv | 39 +++
 rtl/noc_packet_sender.sv | 120 ++++++++++++
 tb/tb_noc_packet_sender.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_packet_sender_pkg.sv
// Shared NoC transmit definitions: default widths, header field layout and the
// packetizer state encoding.
package noc_packet_sender_pkg;

   localparam int NOC_DATA_WIDTH = 32;
   localparam int NOC_COORD_W    = 4;
   localparam int NOC_LEN_W      = 8;

   // Header fields sit in COORD_W-wide slots from bit 0 upward; len follows the last slot.
   localparam int HDR_DX_SLOT  = 0;
   localparam int HDR_DY_SLOT  = 1;
   localparam int HDR_SX_SLOT  = 2;
   localparam int HDR_SY_SLOT  = 3;
   localparam int HDR_LEN_SLOT = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

endpackage

// File: rtl/noc_packet_sender_if.sv
// Handshake bundle between the local IP, the packetizer and the router injection
// port: command channel, payload channel and the outgoing flit channel.
interface noc_packet_sender_if
   import noc_packet_sender_pkg::*;
#(
   parameter int FLIT_W  = NOC_DATA_WIDTH,
   parameter int COORD_W = NOC_COORD_W,
   parameter int LEN_W   = NOC_LEN_W
);

   logic               cmd_valid;
   logic               cmd_ready;
   logic [COORD_W-1:0] cmd_dest_x;
   logic [COORD_W-1:0] cmd_dest_y;
   logic [LEN_W-1:0]   cmd_len;

   logic               pl_valid;
   logic               pl_ready;
   logic [FLIT_W-1:0]  pl_data;

   logic               Noc_send_valid;
   logic               Noc_send_ready;
   logic [FLIT_W-1:0]  Noc_send_flit;
   logic               Noc_send_is_header;
   logic               Noc_send_is_tail;

   modport slave (
      input  cmd_valid, cmd_dest_x, cmd_dest_y, cmd_len,
      input  pl_valid, pl_data,
      input  Noc_send_ready,
      output cmd_ready, pl_ready,
      output Noc_send_valid, Noc_send_flit, Noc_send_is_header, Noc_send_is_tail
   );

   modport master (
      output cmd_valid, cmd_dest_x, cmd_dest_y, cmd_len,
      output pl_valid, pl_data,
      output Noc_send_ready,
      input  cmd_ready, pl_ready,
      input  Noc_send_valid, Noc_send_flit, Noc_send_is_header, Noc_send_is_tail
   );

endinterface

// File: rtl/noc_flit_out_reg.sv
// Single-entry flit output register with valid/ready hold semantics; a load in
// the cycle of a handshake overwrites the register without dropping valid.
module noc_flit_out_reg #(
   parameter int FLIT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [FLIT_W-1:0] load_flit,
   input  logic              load_header,
   input  logic              load_tail,
   input  logic              ready,
   output logic              valid,
   output logic [FLIT_W-1:0] flit,
   output logic              is_header,
   output logic              is_tail,
   output logic              slot_free
);

   assign slot_free = !valid || ready;

   // Callers only assert load when slot_free, so held fields are never disturbed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid     <= 1'b0;
         flit      <= '0;
         is_header <= 1'b0;
         is_tail   <= 1'b0;
      end else if (load) begin
         valid     <= 1'b1;
         flit      <= load_flit;
         is_header <= load_header;
         is_tail   <= load_tail;
      end else if (ready) begin
         valid     <= 1'b0;
      end
   end

endmodule

// File: rtl/noc_packet_sender.sv
// Transmit-side packetizer: turns a (dest, len) command plus a payload word
// stream into one header flit followed by len payload flits for the router.
module noc_packet_sender
   import noc_packet_sender_pkg::*;
#(
   parameter int FLIT_W  = NOC_DATA_WIDTH,
   parameter int COORD_W = NOC_COORD_W,
   parameter int LEN_W   = NOC_LEN_W,
   parameter int SRC_X   = 0,
   parameter int SRC_Y   = 0
) (
   input  logic                 noc_clk,
   input  logic                 rst,
   noc_packet_sender_if.slave   bus,
   output logic                 busy,
   output logic                 pkt_done
);

   localparam int DX_OFF  = HDR_DX_SLOT  * COORD_W;
   localparam int DY_OFF  = HDR_DY_SLOT  * COORD_W;
   localparam int SX_OFF  = HDR_SX_SLOT  * COORD_W;
   localparam int SY_OFF  = HDR_SY_SLOT  * COORD_W;
   localparam int LEN_OFF = HDR_LEN_SLOT * COORD_W;

   state_t             state;
   logic [LEN_W-1:0]   remaining;

   logic               slot_free;
   logic               cmd_hs;
   logic               pl_hs;
   logic               load;
   logic [FLIT_W-1:0]  load_flit;
   logic               load_header;
   logic               load_tail;
   logic [FLIT_W-1:0]  header;

   logic               out_valid;
   logic [FLIT_W-1:0]  out_flit;
   logic               out_header;
   logic               out_tail;

   always_comb begin
      header                         = '0;
      header[DX_OFF  +: COORD_W]     = bus.cmd_dest_x;
      header[DY_OFF  +: COORD_W]     = bus.cmd_dest_y;
      header[SX_OFF  +: COORD_W]     = COORD_W'(SRC_X);
      header[SY_OFF  +: COORD_W]     = COORD_W'(SRC_Y);
      header[LEN_OFF +: LEN_W]       = bus.cmd_len;
   end

   // Readies are gated by rst so every output reads 0 while reset is held.
   assign bus.cmd_ready = !rst && (state == IDLE) && slot_free;
   assign bus.pl_ready  = !rst && (state == BODY) && slot_free;

   assign cmd_hs = bus.cmd_valid && bus.cmd_ready;
   assign pl_hs  = bus.pl_valid  && bus.pl_ready;
   assign load   = cmd_hs || pl_hs;

   always_comb begin
      load_flit   = bus.pl_data;
      load_header = 1'b0;
      load_tail   = (remaining == LEN_W'(1));
      if (cmd_hs) begin
         load_flit   = header;
         load_header = 1'b1;
         load_tail   = (bus.cmd_len == '0);
      end
   end

   noc_flit_out_reg #(
      .FLIT_W (FLIT_W)
   ) u_out (
      .clk         (noc_clk),
      .rst         (rst),
      .load        (load),
      .load_flit   (load_flit),
      .load_header (load_header),
      .load_tail   (load_tail),
      .ready       (bus.Noc_send_ready),
      .valid       (out_valid),
      .flit        (out_flit),
      .is_header   (out_header),
      .is_tail     (out_tail),
      .slot_free   (slot_free)
   );

   assign bus.Noc_send_valid     = out_valid;
   assign bus.Noc_send_flit      = out_flit;
   assign bus.Noc_send_is_header = out_header;
   assign bus.Noc_send_is_tail   = out_tail;

   assign busy = (state != IDLE) || out_valid;

   // remaining is only decremented in BODY, where it is at least 1.
   always_ff @(posedge noc_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         pkt_done  <= 1'b0;
      end else begin
         pkt_done <= out_valid && bus.Noc_send_ready && out_tail;
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  remaining <= bus.cmd_len;
                  if (bus.cmd_len != '0) state <= BODY;
               end
            end
            BODY: begin
               if (pl_hs) begin
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_packet_sender.sv
// Scoreboard bench for noc_packet_sender: accepted commands/payload words push
// expected flits, router-side handshakes pop and compare them.
module tb_noc_packet_sender;

   localparam int FLIT_W  = 32;
   localparam int COORD_W = 4;
   localparam int LEN_W   = 8;
   localparam int SRC_X   = 0;
   localparam int SRC_Y   = 0;

   logic clk;
   logic rst;
   logic busy;
   logic pkt_done;

   int n_vec = 0;
   int n_err = 0;

   logic [33:0]      sb_q[$];
   logic [LEN_W-1:0] m_rem;
   bit               done_pend;

   noc_packet_sender_if #(.FLIT_W(FLIT_W), .COORD_W(COORD_W), .LEN_W(LEN_W)) bus ();

   noc_packet_sender #(
      .FLIT_W (FLIT_W), .COORD_W (COORD_W), .LEN_W (LEN_W),
      .SRC_X  (SRC_X),  .SRC_Y   (SRC_Y)
   ) dut (
      .noc_clk  (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .pkt_done (pkt_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_hdr(input logic [3:0] x, input logic [3:0] y,
                                          input logic [7:0] len);
      return {8'h00, len, 4'(SRC_Y), 4'(SRC_X), y, x};
   endfunction

   // Reference model of the packet flow, sampled on the falling edge.
   initial begin
      m_rem     = '0;
      done_pend = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb_q.delete();
            m_rem     = '0;
            done_pend = 0;
         end else begin
            if (pkt_done || done_pend) chk("pkt_done", 64'(pkt_done), 64'(done_pend));
            done_pend = 0;
            if (bus.cmd_valid && m_rem != 0) chk("cmd_rdy_body", 64'(bus.cmd_ready), 64'd0);
            if (bus.pl_valid && m_rem == 0)  chk("pl_rdy_idle", 64'(bus.pl_ready), 64'd0);
            if (bus.Noc_send_valid && !bus.Noc_send_ready)
               chk("bp_rdy", 64'({bus.cmd_ready, bus.pl_ready}), 64'd0);
            if (bus.Noc_send_valid && bus.Noc_send_ready) begin
               chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
               if (sb_q.size() != 0) begin
                  logic [33:0] e;
                  e = sb_q.pop_front();
                  chk("flit", 64'({bus.Noc_send_is_header, bus.Noc_send_is_tail, bus.Noc_send_flit}),
                      64'(e));
                  done_pend = e[32];
               end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
               sb_q.push_back({1'b1, bus.cmd_len == 8'd0,
                               mk_hdr(bus.cmd_dest_x, bus.cmd_dest_y, bus.cmd_len)});
               m_rem = bus.cmd_len;
            end else if (bus.pl_valid && bus.pl_ready) begin
               sb_q.push_back({1'b0, m_rem == 8'd1, bus.pl_data});
               if (m_rem != 0) m_rem = m_rem - 8'd1;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len);
      bit ok = 0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_dest_x = x;
      bus.cmd_dest_y = y;
      bus.cmd_len    = len;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) ok = 1;
      end
      if (!ok) chk("cmd_timeout", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drive_pl(input logic [31:0] d);
      bit ok = 0;
      bus.pl_valid = 1'b1;
      bus.pl_data  = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.pl_ready) ok = 1;
      end
      if (!ok) chk("pl_timeout", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      bus.pl_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.Noc_send_valid) ok = 1;
      end
      if (!ok) chk("valid_timeout", 64'(ok), 64'd1);
   endtask

   initial begin
      rst                = 1'b1;
      bus.cmd_valid      = 1'b1;
      bus.cmd_dest_x     = '0;
      bus.cmd_dest_y     = '0;
      bus.cmd_len        = '0;
      bus.pl_valid       = 1'b1;
      bus.pl_data        = '0;
      bus.Noc_send_ready = 1'b1;

      idle(2);
      chk("rst_valid",  64'(bus.Noc_send_valid), 64'd0);
      chk("rst_flit",   64'(bus.Noc_send_flit), 64'd0);
      chk("rst_hdr",    64'(bus.Noc_send_is_header), 64'd0);
      chk("rst_tail",   64'(bus.Noc_send_is_tail), 64'd0);
      chk("rst_cmdrdy", 64'(bus.cmd_ready), 64'd0);
      chk("rst_plrdy",  64'(bus.pl_ready), 64'd0);
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_done",   64'(pkt_done), 64'd0);
      bus.cmd_valid = 1'b0;
      bus.pl_valid  = 1'b0;
      rst           = 1'b0;
      idle(1);

      // Basic packet: dest (2,3), three payload words.
      fork
         drive_cmd(4'd2, 4'd3, 8'd3);
         begin
            drive_pl(32'hA1A1_A1A1);
            drive_pl(32'hA2A2_A2A2);
            drive_pl(32'hFFFF_FFFF);
         end
         begin
            wait_valid();
            chk("t1_hdr_const", 64'(bus.Noc_send_flit), 64'h0003_0032);
            chk("t1_is_header", 64'(bus.Noc_send_is_header), 64'd1);
         end
      join
      idle(4);

      // Zero-length packet: header is also the tail, payload never requested.
      fork
         drive_cmd(4'd1, 4'd1, 8'd0);
         begin
            bus.pl_valid = 1'b1;
            bus.pl_data  = 32'hDEAD_BEEF;
            repeat (6) begin
               @(negedge clk);
               chk("t2_pl_rdy", 64'(bus.pl_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            bus.pl_valid = 1'b0;
         end
         begin
            wait_valid();
            chk("t2_flit", 64'({bus.Noc_send_is_header, bus.Noc_send_is_tail, bus.Noc_send_flit}),
                64'({2'b11, 32'h0000_0011}));
         end
      join
      idle(4);

      // Router backpressure right after the header.
      bus.Noc_send_ready = 1'b0;
      fork
         drive_cmd(4'd7, 4'd4, 8'd2);
         begin
            drive_pl(32'h1234_5678);
            drive_pl(32'h8765_4321);
         end
         begin
            wait_valid();
            repeat (5) begin
               chk("t3_stall_flit", 64'(bus.Noc_send_flit), 64'h0002_0047);
               chk("t3_stall_hdr",  64'(bus.Noc_send_is_header), 64'd1);
               chk("t3_stall_rdy",  64'({bus.cmd_ready, bus.pl_ready}), 64'd0);
               chk("t3_busy",       64'(busy), 64'd1);
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            bus.Noc_send_ready = 1'b1;
         end
      join
      idle(4);

      // Back-to-back single-word packets must stream H,P,H,P with no bubble.
      fork
         begin
            drive_cmd(4'd3, 4'd2, 8'd1);
            drive_cmd(4'd0, 4'd15, 8'd1);
         end
         begin
            drive_pl(32'h0000_0001);
            drive_pl(32'h8000_0000);
         end
         begin
            wait_valid();
            for (int i = 0; i < 4; i++) begin
               chk("t4_valid", 64'(bus.Noc_send_valid), 64'd1);
               chk("t4_hdr",   64'(bus.Noc_send_is_header), 64'((i % 2) == 0));
               @(negedge clk);
            end
         end
      join
      idle(4);

      // Payload offered before any command is held off until the header loads.
      fork
         drive_pl(32'h5555_AAAA);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("t5_pl_early", 64'(bus.pl_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            drive_cmd(4'd9, 4'd8, 8'd1);
         end
      join
      idle(4);

      // Reset in the middle of a three-word body, then a fresh packet.
      fork
         drive_cmd(4'd3, 4'd1, 8'd3);
         drive_pl(32'hB1B1_B1B1);
      join
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid",  64'(bus.Noc_send_valid), 64'd0);
      chk("t6_flit",   64'(bus.Noc_send_flit), 64'd0);
      chk("t6_hdr",    64'(bus.Noc_send_is_header), 64'd0);
      chk("t6_tail",   64'(bus.Noc_send_is_tail), 64'd0);
      chk("t6_cmdrdy", 64'(bus.cmd_ready), 64'd0);
      chk("t6_plrdy",  64'(bus.pl_ready), 64'd0);
      chk("t6_busy",   64'(busy), 64'd0);
      chk("t6_done",   64'(pkt_done), 64'd0);
      idle(2);
      rst = 1'b0;
      idle(1);
      fork
         drive_cmd(4'd5, 4'd6, 8'd1);
         drive_pl(32'hC1C1_C1C1);
         begin
            wait_valid();
            chk("t6_fresh_hdr", 64'({bus.Noc_send_is_header, bus.Noc_send_flit}),
                64'({1'b1, 32'h0001_0065}));
         end
      join
      idle(5);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      chk("busy_end",   64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
